// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous SRAM between the CPU bus
// and the VDP fetch port. Every access takes three states:
// IDLE (arbitrate and register the address), ACCESS (the SRAM samples it)
// and CAPTURE (read data is registered and ack is pulsed).
// Arbitration is round-robin. vdp_urgent overrides it, and a CPU
// starvation guard overrides vdp_urgent.
// Optional build macro MEM_ARB_ROM_PROTECT_EN: when it is defined, CPU
// writes at or above ROM_BASE complete normally but never assert ram_we.
module mem_arbiter #(
    parameter int                ADDR_W       = 16,
    parameter int                CPU_MAX_WAIT = 4,
    parameter logic [ADDR_W-1:0] ROM_BASE     = 16'hF800
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              vdp_req,
    input  logic              vdp_urgent,
    input  logic [ADDR_W-1:0] vdp_addr,
    output logic [7:0]        vdp_rdata,
    output logic              vdp_ack,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam logic ROM_PROTECT = 1'b1;
`else
    localparam logic ROM_PROTECT = 1'b0;
`endif

    state_t     state;
    state_t     state_next;
    logic       last_grant_vdp;
    logic [3:0] cpu_wait_ctr;
    logic       owner_vdp;
    logic       owner_write;
    logic       cpu_elig;
    logic       vdp_elig;
    logic       grant_cpu;
    logic       grant_vdp;
    logic       cpu_write_en;

    // A requester whose ack is high this cycle is still finishing its
    // previous access, so it cannot be granted again yet.
    assign cpu_elig = cpu_req & ~cpu_ack;
    assign vdp_elig = vdp_req & ~vdp_ack;

    // A protected ROM write still runs the full sequence, but without the strobe.
    assign cpu_write_en = cpu_we & ~(ROM_PROTECT & (cpu_addr >= ROM_BASE));

    // Winner selection in IDLE: sole requester, then starvation guard, then urgent, then round-robin.
    always_comb begin
        grant_cpu = 1'b0;
        grant_vdp = 1'b0;
        if (state == IDLE) begin
            if (cpu_elig && !vdp_elig) begin
                grant_cpu = 1'b1;
            end else if (vdp_elig && !cpu_elig) begin
                grant_vdp = 1'b1;
            end else if (cpu_elig && vdp_elig) begin
                if (cpu_wait_ctr >= MAX_WAIT) begin
                    grant_cpu = 1'b1;
                end else if (vdp_urgent) begin
                    grant_vdp = 1'b1;
                end else if (last_grant_vdp) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_vdp = 1'b1;
                end
            end
        end
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic for the three-step access sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_cpu || grant_vdp) state_next = ACCESS;
            ACCESS:  state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SRAM drive, ownership, fairness tracking, read-data capture and ack pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_addr       <= '0;
            ram_wdata      <= '0;
            ram_we         <= 1'b0;
            cpu_rdata      <= '0;
            vdp_rdata      <= '0;
            cpu_ack        <= 1'b0;
            vdp_ack        <= 1'b0;
            last_grant_vdp <= 1'b1;
            cpu_wait_ctr   <= '0;
            owner_vdp      <= 1'b0;
            owner_write    <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            vdp_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        ram_addr       <= cpu_addr;
                        ram_wdata      <= cpu_wdata;
                        ram_we         <= cpu_write_en;
                        last_grant_vdp <= 1'b0;
                        owner_vdp      <= 1'b0;
                        owner_write    <= cpu_we;
                        cpu_wait_ctr   <= '0;
                    end else if (grant_vdp) begin
                        ram_addr       <= vdp_addr;
                        ram_wdata      <= cpu_wdata;
                        ram_we         <= 1'b0;
                        last_grant_vdp <= 1'b1;
                        owner_vdp      <= 1'b1;
                        owner_write    <= 1'b0;
                        if (cpu_elig && cpu_wait_ctr != 4'hF) begin
                            cpu_wait_ctr <= cpu_wait_ctr + 4'd1;
                        end
                    end else begin
                        ram_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    ram_we <= 1'b0;
                end
                CAPTURE: begin
                    if (owner_vdp) begin
                        vdp_rdata <= ram_rdata;
                        vdp_ack   <= 1'b1;
                    end else begin
                        if (!owner_write) begin
                            cpu_rdata <= ram_rdata;
                        end
                        cpu_ack <= 1'b1;
                    end
                end
                default: begin
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural SRAM.
// It covers CPU read/write latency, round-robin alternation, the urgent
// override with the starvation guard, abort on reset, and the ROM window.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;

`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam int ROM_WE_EXP = 0;
`else
    localparam int ROM_WE_EXP = 1;
`endif

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_ack;
    logic              vdp_req;
    logic              vdp_urgent;
    logic [ADDR_W-1:0] vdp_addr;
    logic [7:0]        vdp_rdata;
    logic              vdp_ack;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [7:0]        ram_rdata;

    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic [7:0]        mem [0:65535];

    int err_count   = 0;
    int check_count = 0;

    mem_arbiter #(
        .ADDR_W       (16),
        .CPU_MAX_WAIT (4),
        .ROM_BASE     (16'hF800)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .vdp_req    (vdp_req),
        .vdp_urgent (vdp_urgent),
        .vdp_addr   (vdp_addr),
        .vdp_rdata  (vdp_rdata),
        .vdp_ack    (vdp_ack),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_rdata  (ram_rdata)
    );

    // 100 MHz memory clock
    always #5 clk = ~clk;

    // Synchronous SRAM: read data appears one clock after the address is sampled
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadWord(input logic [15:0] addr, input logic [7:0] data);
        load_en   = 1'b1;
        load_addr = addr;
        load_data = data;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // One CPU transaction from a negedge in IDLE; reports ack cycle and ram_we activity
    task automatic applyStimulus(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                                 output int ack_cycle, output int we_count, output logic [15:0] first_addr,
                                 output logic [15:0] we_addr, output logic [7:0] we_data);
        ack_cycle  = 0;
        we_count   = 0;
        first_addr = '0;
        we_addr    = '0;
        we_data    = '0;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        cpu_req    = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) first_addr = ram_addr;
            if (ram_we) begin
                we_count++;
                we_addr = ram_addr;
                we_data = ram_wdata;
            end
            if (cpu_ack) begin
                ack_cycle = c;
                break;
            end
        end
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    int          ack_cycle;
    int          we_count;
    logic [15:0] first_addr;
    logic [15:0] we_addr;
    logic [7:0]  we_data;
    int          n_acks;
    int          last_ack;
    int          first_ack;
    int          spacing_bad;
    int          coincide;
    int          ack_seen;
    logic        cpu_done;
    logic [3:0]  order4;
    logic [5:0]  order6;

    // Directed sequence
    initial begin
        reset_n    = 1'b0;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_wdata  = '0;
        vdp_req    = 1'b0;
        vdp_urgent = 1'b0;
        vdp_addr   = '0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        @(negedge clk);
        loadWord(16'h0200, 8'h5A);
        loadWord(16'h0300, 8'h3C);
        loadWord(16'h0020, 8'hEE);

        checkOutput("reset_ram_addr", 32'(ram_addr), 32'h0);
        checkOutput("reset_ram_we", 32'(ram_we), 32'h0);
        checkOutput("reset_ram_wdata", 32'(ram_wdata), 32'h0);
        checkOutput("reset_acks", 32'({cpu_ack, vdp_ack}), 32'h0);
        checkOutput("reset_rdata", 32'({cpu_rdata, vdp_rdata}), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 16'h0200, 8'h00, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("rd_addr_after_e0", 32'(first_addr), 32'h0200);
        checkOutput("rd_ack_cycle", 32'(ack_cycle), 32'd3);
        checkOutput("rd_we_count", 32'(we_count), 32'd0);
        checkOutput("rd_data", 32'(cpu_rdata), 32'h5A);

        applyStimulus(1'b1, 16'h0010, 8'hC3, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("wr_ack_cycle", 32'(ack_cycle), 32'd3);
        checkOutput("wr_we_count", 32'(we_count), 32'd1);
        checkOutput("wr_we_addr", 32'(we_addr), 32'h0010);
        checkOutput("wr_we_data", 32'(we_data), 32'hC3);
        checkOutput("wr_rdata_held", 32'(cpu_rdata), 32'h5A);

        applyStimulus(1'b0, 16'h0010, 8'h00, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("rdback_data", 32'(cpu_rdata), 32'hC3);

        pulseReset();
        n_acks = 0; last_ack = 0; first_ack = 0; spacing_bad = 0; coincide = 0; order4 = '0;
        cpu_we = 1'b0; cpu_addr = 16'h0200; vdp_addr = 16'h0300; vdp_urgent = 1'b0;
        cpu_req = 1'b1; vdp_req = 1'b1;
        for (int c = 1; c <= 40 && n_acks < 4; c++) begin
            @(negedge clk);
            if (cpu_ack && vdp_ack) coincide++;
            if (cpu_ack || vdp_ack) begin
                order4[n_acks] = vdp_ack;
                if (n_acks == 0) first_ack = c;
                else if (c - last_ack != 3) spacing_bad++;
                last_ack = c;
                n_acks++;
            end
            if (n_acks == 4) begin
                cpu_req = 1'b0;
                vdp_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        vdp_req = 1'b0;
        @(negedge clk);
        checkOutput("rr_ack_count", 32'(n_acks), 32'd4);
        checkOutput("rr_order", 32'(order4), 32'b1010);
        checkOutput("rr_first_ack", 32'(first_ack), 32'd3);
        checkOutput("rr_spacing", 32'(spacing_bad), 32'd0);
        checkOutput("rr_coincide", 32'(coincide), 32'd0);
        checkOutput("rr_cpu_rdata", 32'(cpu_rdata), 32'h5A);
        checkOutput("rr_vdp_rdata", 32'(vdp_rdata), 32'h3C);

        pulseReset();
        n_acks = 0; coincide = 0; order6 = '0; cpu_done = 1'b0;
        cpu_we = 1'b0; cpu_addr = 16'h0200; vdp_addr = 16'h0300; vdp_urgent = 1'b1;
        cpu_req = 1'b1; vdp_req = 1'b1;
        for (int c = 1; c <= 80 && n_acks < 6; c++) begin
            @(negedge clk);
            if (cpu_ack && vdp_ack) coincide++;
            if (cpu_ack || vdp_ack) begin
                order6[n_acks] = vdp_ack;
                n_acks++;
            end
            if (cpu_ack) cpu_done = 1'b1;
            cpu_req = cpu_done ? 1'b0 : !vdp_ack;
            if (n_acks == 6) vdp_req = 1'b0;
        end
        cpu_req = 1'b0;
        vdp_req = 1'b0;
        @(negedge clk);
        vdp_urgent = 1'b0;
        checkOutput("urg_ack_count", 32'(n_acks), 32'd6);
        checkOutput("urg_order", 32'(order6), 32'b101111);
        checkOutput("urg_coincide", 32'(coincide), 32'd0);
        checkOutput("urg_wait_ctr", 32'(dut.cpu_wait_ctr), 32'd0);

        cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h77; cpu_req = 1'b1;
        @(negedge clk);
        checkOutput("abort_we_access", 32'(ram_we), 32'd1);
        #2 reset_n = 1'b0;
        #1 checkOutput("abort_we_async", 32'(ram_we), 32'd0);
        ack_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack) ack_seen++;
        end
        cpu_req = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        if (cpu_ack) ack_seen++;
        checkOutput("abort_no_ack", 32'(ack_seen), 32'd0);
        checkOutput("abort_mem_intact", 32'(mem[16'h0020]), 32'hEE);
        applyStimulus(1'b1, 16'h0020, 8'h77, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("abort_retry_ack", 32'(ack_cycle), 32'd3);
        checkOutput("abort_retry_we", 32'(we_count), 32'd1);
        applyStimulus(1'b0, 16'h0020, 8'h00, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("abort_retry_data", 32'(cpu_rdata), 32'h77);

        applyStimulus(1'b1, 16'hF800, 8'h11, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("rom_base_ack", 32'(ack_cycle), 32'd3);
        checkOutput("rom_base_we", 32'(we_count), 32'(ROM_WE_EXP));
        applyStimulus(1'b1, 16'hF7FF, 8'h22, ack_cycle, we_count, first_addr, we_addr, we_data);
        checkOutput("below_rom_ack", 32'(ack_cycle), 32'd3);
        checkOutput("below_rom_we", 32'(we_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
